// File: rtl/edge_delay_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_delay_mc_pkg
// Purpose  : Shared definitions for the multi-channel edge delay block:
//            mode encoding, the counter container type and the saturating
//            delay-to-load conversion used by every channel.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package edge_delay_mc_pkg;

   // Mode encoding for the global mode input.
   typedef enum logic {
      MODE_HOLD   = 1'b0,   // counter freezes while an edge is withdrawn
      MODE_FILTER = 1'b1    // counter restarts while an edge is withdrawn
   } mode_e;

   // Widest delay counter supported. Channels size their counter with their
   // own DW parameter and move values through this container type, so DW
   // may be anything from 1 up to CNT_MAX_W.
   localparam int CNT_MAX_W = 32;
   typedef logic [CNT_MAX_W-1:0] cnt_max_t;

   // Counter load for a programmed delay: dly-1, but 0 stays 0 so a zero
   // delay behaves like a one-cycle delay instead of wrapping to 2^DW-1.
   function automatic cnt_max_t sat_dec(input cnt_max_t dly);
      return (dly == '0) ? '0 : (dly - cnt_max_t'(1));
   endfunction

endpackage : edge_delay_mc_pkg
`default_nettype wire

// File: rtl/edge_delay_ch.sv
`default_nettype none
// ============================================================================
// Module   : edge_delay_ch
// Purpose  : One channel of the edge delay block: input synchronizer,
//            delay down-counter, registered output and edge strobes.
// Ports    : clk, rst_n          clock, async active-low reset
//            en                  freeze counter/output when low
//            mode                MODE_HOLD / MODE_FILTER
//            rise_dly, fall_dly  delay in cycles for rising / falling edges
//            sgn_in              asynchronous input
//            sgn_out             delayed output (registered)
//            rise_pulse          1-cycle strobe after sgn_out rose
//            fall_pulse          1-cycle strobe after sgn_out fell
//            busy                synchronized input differs from sgn_out
// Revision : 1.0  initial release
// ============================================================================
module edge_delay_ch
   import edge_delay_mc_pkg::*;
#(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          mode,
   input  logic [DW-1:0] rise_dly,
   input  logic [DW-1:0] fall_dly,
   input  logic          sgn_in,
   output logic          sgn_out,
   output logic          rise_pulse,
   output logic          fall_pulse,
   output logic          busy
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sgn_s;
   logic [DW-1:0]          cnt;
   logic                   out_prev;
   logic [DW-1:0]          dly_sel;
   logic [DW-1:0]          load_val;

   assign sgn_s = sync_q[SYNC_STAGES-1];

   // The delay to load is always the one for the edge that would come next
   // once sgn_out equals sgn_s: after accepting a rise (sgn_s=1) the next
   // edge is a fall, and while idle at 1 the pending edge is also a fall.
   // So a single select on sgn_s serves both the accept and the reload case.
   assign dly_sel  = sgn_s ? fall_dly : rise_dly;
   assign load_val = DW'(sat_dec(cnt_max_t'(dly_sel)));

   assign busy = sgn_s ^ sgn_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         cnt        <= '0;
         sgn_out    <= 1'b0;
         out_prev   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         // Synchronizer runs regardless of en.
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sgn_in};
         out_prev <= sgn_out;
         if (en) begin
            // out_prev lags sgn_out by one cycle, so the strobe lands in
            // the cycle after sgn_out changed.
            rise_pulse <= sgn_out & ~out_prev;
            fall_pulse <= ~sgn_out & out_prev;
            if (sgn_s != sgn_out) begin
               if (cnt != '0) begin
                  cnt <= cnt - DW'(1);
               end else begin
                  sgn_out <= sgn_s;
                  cnt     <= load_val;
               end
            end else if (mode == MODE_FILTER) begin
               cnt <= load_val;
            end
         end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
         end
      end
   end

endmodule : edge_delay_ch
`default_nettype wire

// File: rtl/edge_delay_mc.sv
`default_nettype none
// ============================================================================
// Module   : edge_delay_mc
// Purpose  : Multi-channel edge delay / glitch filter. Each channel delays
//            rising and falling edges of an asynchronous input by shared,
//            programmable cycle counts.
// Ports    : clk, rst_n          clock, async active-low reset
//            en                  global enable
//            mode                0 = hold, 1 = filter
//            rise_dly, fall_dly  shared edge delays (cycles)
//            sgn_in  [CH]        asynchronous inputs
//            sgn_out [CH]        delayed outputs
//            rise_pulse [CH]     strobe after sgn_out rose
//            fall_pulse [CH]     strobe after sgn_out fell
//            busy [CH]           edge pending on the channel
// Revision : 1.0  initial release
// ============================================================================
module edge_delay_mc
   import edge_delay_mc_pkg::*;
#(
   parameter int CH          = 4,
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          mode,
   input  logic [DW-1:0] rise_dly,
   input  logic [DW-1:0] fall_dly,
   input  logic [CH-1:0] sgn_in,
   output logic [CH-1:0] sgn_out,
   output logic [CH-1:0] rise_pulse,
   output logic [CH-1:0] fall_pulse,
   output logic [CH-1:0] busy
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_delay_ch #(
         .DW          (DW),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .mode       (mode),
         .rise_dly   (rise_dly),
         .fall_dly   (fall_dly),
         .sgn_in     (sgn_in[i]),
         .sgn_out    (sgn_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .busy       (busy[i])
      );
   end

endmodule : edge_delay_mc
`default_nettype wire

// File: tb/tb_edge_delay_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_delay_mc
// Purpose  : Self-checking bench for edge_delay_mc. Expected output edges
//            and strobes are queued with their due cycle when the input is
//            driven; a monitor pops them as the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_edge_delay_mc;
   import edge_delay_mc_pkg::*;

   localparam int CH = 4;
   localparam int DW = 8;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          mode;
   logic [DW-1:0] rise_dly;
   logic [DW-1:0] fall_dly;
   logic [CH-1:0] sgn_in;
   logic [CH-1:0] sgn_out;
   logic [CH-1:0] rise_pulse;
   logic [CH-1:0] fall_pulse;
   logic [CH-1:0] busy;

   always #5 clk = ~clk;

   edge_delay_mc #(
      .CH          (CH),
      .DW          (DW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .rise_dly   (rise_dly),
      .fall_dly   (fall_dly),
      .sgn_in     (sgn_in),
      .sgn_out    (sgn_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy)
   );

   // kind: 0 = sgn_out rose, 1 = sgn_out fell, 2 = rise_pulse, 3 = fall_pulse
   typedef struct {
      int cyc;
      int ch;
      int kind;
   } evt_t;

   evt_t          expq[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic [CH-1:0] out_prev = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_edge(input int ch, input bit rising, input int at);
      evt_t e;
      e.ch   = ch;
      e.cyc  = at;
      e.kind = rising ? 0 : 1;
      expq.push_back(e);
      e.cyc  = at + 1;
      e.kind = rising ? 2 : 3;
      expq.push_back(e);
   endtask

   task automatic match_evt(input int ch, input int kind);
      int idx = -1;
      for (int k = 0; k < expq.size(); k++) begin
         if (expq[k].ch == ch && expq[k].kind == kind) begin
            idx = k;
            break;
         end
      end
      check_eq($sformatf("evt_expected ch%0d kind%0d cyc%0d", ch, kind, cyc), 32'(idx >= 0), 1);
      if (idx >= 0) begin
         check_eq($sformatf("evt_cycle ch%0d kind%0d", ch, kind), cyc, expq[idx].cyc);
         expq.delete(idx);
      end
   endtask

   // Monitor: samples 1 ns after each rising edge, cyc = posedges so far.
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < CH; i++) begin
         if (sgn_out[i] !== out_prev[i]) match_evt(i, sgn_out[i] ? 0 : 1);
         if (rise_pulse[i] === 1'b1)     match_evt(i, 2);
         if (fall_pulse[i] === 1'b1)     match_evt(i, 3);
      end
      out_prev = sgn_out;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      mode     = MODE_HOLD;
      rise_dly = 8'd5;
      fall_dly = 8'd3;
      sgn_in   = '0;
      step(3);
      check_eq("rst_sgn_out", 32'(sgn_out), 0);
      check_eq("rst_rise_pulse", 32'(rise_pulse), 0);
      check_eq("rst_fall_pulse", 32'(fall_pulse), 0);
      check_eq("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      step(3);

      // First edge after reset: one cycle after sync despite rise_dly=5.
      sgn_in[0] = 1'b1;
      expect_edge(0, 1'b1, cyc + SS + 1);
      step(SS);
      check_eq("busy_pending", 32'(busy[0]), 1);
      check_eq("out_pending", 32'(sgn_out[0]), 0);
      step(4);
      check_eq("out_after_rise", 32'(sgn_out[0]), 1);
      check_eq("busy_cleared", 32'(busy[0]), 0);

      // Falling edge with fall_dly=3 (loaded at the rise). rise_dly=6 is
      // picked up by the load that happens when this fall is accepted.
      rise_dly  = 8'd6;
      sgn_in[0] = 1'b0;
      expect_edge(0, 1'b0, cyc + SS + 3);
      step(8);

      // Hold mode: 3 high, 2 low, then high -> 3 more cycles to rise.
      sgn_in[0] = 1'b1;
      step(3);
      sgn_in[0] = 1'b0;
      step(2);
      sgn_in[0] = 1'b1;
      expect_edge(0, 1'b1, cyc + SS + 3);
      step(7);
      check_eq("out_hold_mode", 32'(sgn_out[0]), 1);
      sgn_in[0] = 1'b0;
      expect_edge(0, 1'b0, cyc + SS + 3);
      step(8);

      // Filter mode: a 4-cycle pulse is swallowed, a 6-cycle one passes.
      mode      = MODE_FILTER;
      sgn_in[0] = 1'b1;
      step(4);
      sgn_in[0] = 1'b0;
      step(10);
      check_eq("filter_short_glitch", 32'(sgn_out[0]), 0);
      sgn_in[0] = 1'b1;
      expect_edge(0, 1'b1, cyc + SS + 6);
      step(10);

      // Zero delays: single-cycle latency, no wrap.
      rise_dly = 8'd0;
      fall_dly = 8'd0;
      step(2);
      sgn_in[0] = 1'b0;
      expect_edge(0, 1'b0, cyc + SS + 1);
      step(5);
      mode = MODE_HOLD;

      // All channels at once.
      sgn_in = '1;
      for (int c = 0; c < CH; c++) expect_edge(c, 1'b1, cyc + SS + 1);
      step(5);
      check_eq("all_high", 32'(sgn_out), 32'hF);
      sgn_in = '0;
      for (int c = 0; c < CH; c++) expect_edge(c, 1'b0, cyc + SS + 1);
      step(5);

      // Enable low for 10 cycles in the middle of an 8-cycle fall delay.
      rise_dly  = 8'd8;
      fall_dly  = 8'd8;
      sgn_in[0] = 1'b1;
      expect_edge(0, 1'b1, cyc + SS + 1);
      step(6);
      sgn_in[0] = 1'b0;
      expect_edge(0, 1'b0, cyc + SS + 8 + 10);
      step(4);
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         check_eq("en0_out_held", 32'(sgn_out[0]), 1);
         check_eq("en0_busy", 32'(busy[0]), 1);
      end
      en = 1'b1;
      step(8);

      // Reset in the middle of a pending rise: discarded, no strobe.
      sgn_in[0] = 1'b1;
      step(5);
      rst_n     = 1'b0;
      sgn_in[0] = 1'b0;
      #1;
      check_eq("midrst_out", 32'(sgn_out), 0);
      check_eq("midrst_pulses", 32'(rise_pulse | fall_pulse), 0);
      check_eq("midrst_busy", 32'(busy), 0);
      step(3);
      rst_n = 1'b1;
      step(10);
      check_eq("post_rst_out", 32'(sgn_out), 0);

      // First edge after this reset again takes one cycle.
      sgn_in[0] = 1'b1;
      expect_edge(0, 1'b1, cyc + SS + 1);
      step(6);

      check_eq("pending_evts", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_edge_delay_mc
`default_nettype wire

// File: doc/edge_delay_mc.md
EDGE_DELAY_MC -- requirements
Module: edge_delay_mc

Interface
REQ-001 Parameter CH, default 4, number of independent channels (1..16).
REQ-002 Parameter DW, default 8, delay counter width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flop depth (>=2).
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  global enable; 0 freezes counters and outputs.
REQ-007 mode  input  1  0 = hold mode (counter holds on glitch), 1 = filter mode (counter reloads on glitch).
REQ-008 rise_dly  input  DW  cycles a rising edge is delayed; shared by all channels.
REQ-009 fall_dly  input  DW  cycles a falling edge is delayed; shared by all channels.
REQ-010 sgn_in  input  CH  asynchronous input signals.
REQ-011 sgn_out  output  CH  delayed/filtered signals, registered.
REQ-012 rise_pulse  output  CH  one-cycle strobe when sgn_out[i] goes 0->1.
REQ-013 fall_pulse  output  CH  one-cycle strobe when sgn_out[i] goes 1->0.
REQ-014 busy  output  CH  1 while sgn_s[i] != sgn_out[i] (edge pending).

Function
REQ-015 Each sgn_in[i] SHALL pass a SYNC_STAGES-flop synchronizer producing sgn_s[i]; channels are otherwise independent.
REQ-016 Each channel SHALL hold a DW-bit down-counter cnt[i].
REQ-017 With en=1 and sgn_s[i] != sgn_out[i]: if cnt[i] != 0, cnt[i] decrements; else sgn_out[i] <= sgn_s[i] and cnt[i] is loaded for the next (opposite) edge.
REQ-018 Load value after accepting a rising edge SHALL be fall_dly-1; after a falling edge rise_dly-1; dly=0 SHALL load 0 (saturate, no wrap).
REQ-019 Edge latency from sgn_s change SHALL be max(dly,1) cycles; total from sgn_in is that plus SYNC_STAGES.
REQ-020 Delay values SHALL be sampled only at load; changes mid-count affect the next edge only.
REQ-021 mode=0: when sgn_s[i] returns equal to sgn_out[i] before cnt reaches 0, cnt[i] SHALL hold its value.
REQ-022 mode=1: in the same case, cnt[i] SHALL reload with the delay for the pending polarity minus 1 (saturating), so only pulses >= dly cycles pass.
REQ-023 rise_pulse/fall_pulse SHALL assert in the cycle after sgn_out[i] changes, for exactly one cycle.
REQ-024 en=0: cnt, sgn_out held, pulses 0; synchronizer keeps running; busy still reflects mismatch.
REQ-025 Simultaneous edges on several channels SHALL be handled independently in the same cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear synchronizer flops, sgn_out, rise_pulse, fall_pulse, busy and cnt to 0.
REQ-027 Because cnt=0 after reset, the first edge after reset SHALL be accepted with 1-cycle latency regardless of dly.
REQ-028 Reset asserted mid-count SHALL discard the pending edge; release SHALL be clean with no spurious pulse.

Structure
REQ-029 Shared package SHALL hold the mode encoding constants (MODE_HOLD=0, MODE_FILTER=1) and a DW-parameterised counter type.
REQ-030 One sub-module edge_delay_ch SHALL implement a single channel (sync, counter, output, pulses); top instantiates CH copies via generate.

Verification
REQ-031 Reset release, rise_dly=5, sgn_in[0] 0->1 -> sgn_out[0]=1 at SYNC_STAGES+1 cycles, rise_pulse[0] one cycle later (first-edge rule).
REQ-032 Then fall_dly=3, sgn_in[0] 1->0 -> sgn_out[0]=0 exactly 3 cycles after sgn_s falls; fall_pulse[0] single cycle.
REQ-033 mode=0, rise_dly=6, 3-cycle high glitch then 2 low then high -> output rises after 3 more high cycles (counter held).
REQ-034 mode=1, rise_dly=6, 4-cycle high glitch -> sgn_out stays 0; 6-cycle high -> sgn_out rises.
REQ-035 rise_dly=0 and fall_dly=0 -> 1-cycle latency after sync, no 2^DW wrap delay.
REQ-036 en=0 mid-count for 10 cycles then en=1 -> edge lands 10 cycles later; rst_n pulse mid-count -> all outputs 0, no pulse.
